// File: rtl/sm_run_ctrl_pkg.sv
// sm_run_ctrl_pkg
//   Shared constants for the schoolMIPS run/halt/step controller: command
//   op codes, FSM state encodings and the dump index range. The testbench
//   imports the same package so its status printing and stimulus agree with
//   the RTL encoding.
package sm_run_ctrl_pkg;

    // Command op codes carried on cmd_op
    localparam logic [1:0] OP_RUN  = 2'd0;
    localparam logic [1:0] OP_HALT = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_DUMP = 2'd3;

    // Controller FSM state encodings
    localparam logic [2:0] ST_HALT     = 3'd0;
    localparam logic [2:0] ST_RUN      = 3'd1;
    localparam logic [2:0] ST_STEP     = 3'd2;
    localparam logic [2:0] ST_DUMP_RD  = 3'd3;
    localparam logic [2:0] ST_DUMP_OUT = 3'd4;

    // Last register index streamed by a dump ($31)
    localparam logic [4:0] LAST_REG_IDX = 5'd31;

    // True in the states where the core clock may be enabled
    function automatic logic is_exec_state(input logic [2:0] st);
        return (st == ST_RUN) || (st == ST_STEP);
    endfunction

endpackage

// File: rtl/sm_reg_dump.sv
// sm_reg_dump
//   Register dump sequencer. Holds the register index (which is also the
//   value driven on reg_addr) and the dump stream output registers.
//   The controller FSM tells it which dump phase it is in:
//     rd_phase  : reg_addr already points at the current index, so reg_data
//                 is captured into dump_data/dump_idx and dump_valid rises.
//     out_phase : dump_valid is held until dump_ready; on the handshake the
//                 index advances (or returns to 0 after $31).
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     start               DUMP accepted: restart at index 0
//     rd_phase, out_phase current dump phase from the controller
//     reg_data            combinational register read data
//     reg_addr            register read address (0 outside a dump)
//     dump_valid/ready    stream handshake
//     dump_idx, dump_data stream payload
//     beat_done           handshake completes this cycle
//     done                handshake of the final beat ($31)
module sm_reg_dump
    import sm_run_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rd_phase,
    input  logic        out_phase,
    input  logic [31:0] reg_data,
    output logic [4:0]  reg_addr,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_idx,
    output logic [31:0] dump_data,
    output logic        beat_done,
    output logic        done
);

    logic [4:0]  reg_addr_r;
    logic        dump_valid_r;
    logic [4:0]  dump_idx_r;
    logic [31:0] dump_data_r;
    logic        last_s;

    assign last_s     = (reg_addr_r == LAST_REG_IDX);
    assign beat_done  = out_phase && dump_valid_r && dump_ready;
    assign done       = beat_done && last_s;
    assign reg_addr   = reg_addr_r;
    assign dump_valid = dump_valid_r;
    assign dump_idx   = dump_idx_r;
    assign dump_data  = dump_data_r;

    // Index counter, capture of read data and valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_addr_r   <= 5'd0;
            dump_valid_r <= 1'b0;
            dump_idx_r   <= 5'd0;
            dump_data_r  <= 32'd0;
        end else begin
            // Advancing the address on the handshake lets the next read
            // phase capture straight away, giving two cycles per beat.
            if (start) begin
                reg_addr_r <= 5'd0;
            end else if (beat_done) begin
                reg_addr_r <= last_s ? 5'd0 : (reg_addr_r + 5'd1);
            end else begin
                reg_addr_r <= reg_addr_r;
            end

            if (rd_phase) begin
                dump_data_r  <= reg_data;
                dump_idx_r   <= reg_addr_r;
                dump_valid_r <= 1'b1;
            end else if (beat_done) begin
                dump_valid_r <= 1'b0;
            end else begin
                dump_valid_r <= dump_valid_r;
            end
        end
    end

endmodule

// File: rtl/sm_run_ctrl.sv
// sm_run_ctrl
//   Run/halt/step controller for the schoolMIPS core. Gates the core clock
//   enable, stops on a PC breakpoint, single-steps N cycles and, while
//   halted, streams out the PC and registers $1..$31 via sm_reg_dump.
//   Ports:
//     clk, rst_n                    core clock, asynchronous active-low reset
//     cmd_valid/cmd_ready           command handshake
//     cmd_op, cmd_arg               op code and STEP cycle count
//     bp_en, bp_pc                  breakpoint enable and PC word index
//     cpu_en                        core clock enable (combinational)
//     reg_addr, reg_data            core register debug port
//     dump_valid/ready, dump_idx,
//     dump_data                     register dump stream
//     halted                        controller is in HALT
//     bp_hit                        last stop came from the breakpoint
module sm_run_ctrl
    import sm_run_ctrl_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int RUN_ON_RESET = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic             bp_en,
    input  logic [31:0]      bp_pc,
    output logic             cpu_en,
    output logic [4:0]       reg_addr,
    input  logic [31:0]      reg_data,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [4:0]       dump_idx,
    output logic [31:0]      dump_data,
    output logic             halted,
    output logic             bp_hit
);

    localparam logic [2:0]       RESET_STATE = (RUN_ON_RESET != 0) ? ST_RUN : ST_HALT;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);

    logic [2:0]       state_r;
    logic [2:0]       state_nx_s;
    logic [CNT_W-1:0] step_cnt_r;
    logic [CNT_W-1:0] step_cnt_nx_s;
    logic             arm_r;
    logic             arm_nx_s;
    logic             bp_hit_r;
    logic             bp_hit_nx_s;
    logic             cmd_acc_s;
    logic             exec_s;
    logic             bp_match_s;
    logic             dump_start_s;
    logic             beat_done_s;
    logic             dump_done_s;

    assign cmd_ready = (state_r == ST_HALT) || exec_s;
    assign cmd_acc_s = cmd_valid && cmd_ready;
    assign exec_s    = is_exec_state(state_r);
    assign halted    = (state_r == ST_HALT);
    assign bp_hit    = bp_hit_r;

    // reg_addr is 0 outside a dump, so reg_data is the PC here. arm_r is
    // clear for the first enabled cycle so a resume from the breakpointed
    // PC executes that instruction instead of stopping again.
    assign bp_match_s = arm_r && bp_en && (reg_data == bp_pc);
    assign cpu_en     = exec_s && !bp_match_s;

    // Next-state, step counter, arm and breakpoint flag decode
    always_comb begin
        state_nx_s    = state_r;
        step_cnt_nx_s = step_cnt_r;
        arm_nx_s      = cpu_en ? 1'b1 : arm_r;
        bp_hit_nx_s   = bp_hit_r;
        dump_start_s  = 1'b0;

        case (state_r)
            ST_HALT: begin
                if (cmd_acc_s) begin
                    case (cmd_op)
                        OP_RUN: begin
                            state_nx_s  = ST_RUN;
                            arm_nx_s    = 1'b0;
                            bp_hit_nx_s = 1'b0;
                        end
                        OP_STEP: begin
                            if (cmd_arg != '0) begin
                                state_nx_s    = ST_STEP;
                                step_cnt_nx_s = cmd_arg;
                                arm_nx_s      = 1'b0;
                                bp_hit_nx_s   = 1'b0;
                            end else begin
                                state_nx_s = ST_HALT;
                            end
                        end
                        OP_DUMP: begin
                            state_nx_s   = ST_DUMP_RD;
                            dump_start_s = 1'b1;
                        end
                        default: begin
                            state_nx_s = ST_HALT;
                        end
                    endcase
                end else begin
                    state_nx_s = ST_HALT;
                end
            end
            ST_RUN, ST_STEP: begin
                if ((state_r == ST_STEP) && cpu_en) begin
                    step_cnt_nx_s = step_cnt_r - CNT_ONE;
                end else begin
                    step_cnt_nx_s = step_cnt_r;
                end
                // Breakpoint wins over a simultaneous HALT or step expiry so
                // bp_hit always reports it.
                if (bp_match_s) begin
                    state_nx_s  = ST_HALT;
                    bp_hit_nx_s = 1'b1;
                end else if (cmd_acc_s && (cmd_op == OP_HALT)) begin
                    state_nx_s = ST_HALT;
                end else if ((state_r == ST_STEP) && cpu_en && (step_cnt_r == CNT_ONE)) begin
                    state_nx_s = ST_HALT;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_DUMP_RD: begin
                state_nx_s = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                if (dump_done_s) begin
                    state_nx_s = ST_HALT;
                end else if (beat_done_s) begin
                    state_nx_s = ST_DUMP_RD;
                end else begin
                    state_nx_s = ST_DUMP_OUT;
                end
            end
            default: begin
                state_nx_s = ST_HALT;
            end
        endcase
    end

    // Controller state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= RESET_STATE;
            step_cnt_r <= '0;
            arm_r      <= 1'b0;
            bp_hit_r   <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            step_cnt_r <= step_cnt_nx_s;
            arm_r      <= arm_nx_s;
            bp_hit_r   <= bp_hit_nx_s;
        end
    end

    sm_reg_dump u_dump (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (dump_start_s),
        .rd_phase   (state_r == ST_DUMP_RD),
        .out_phase  (state_r == ST_DUMP_OUT),
        .reg_data   (reg_data),
        .reg_addr   (reg_addr),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .beat_done  (beat_done_s),
        .done       (dump_done_s)
    );

endmodule

// File: tb/tb_sm_run_ctrl.sv
// tb_sm_run_ctrl
//   Self-checking bench for sm_run_ctrl. A behavioural core model advances
//   its PC on each enabled clock and answers reg_addr reads from a local
//   register file. A vector table covers the command decode; hand-written
//   sequences cover breakpoints, dumping and asynchronous reset.
module tb_sm_run_ctrl;
    import sm_run_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic        bp_en;
    logic [31:0] bp_pc;
    logic        cpu_en;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        halted;
    logic        bp_hit;

    logic [31:0] pc;
    logic        pc_load;
    logic [31:0] pc_load_val;
    logic [31:0] rf [32];

    int total;
    int bad;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] arg;
        int          extra;
        logic        exp_halted;
        int          exp_delta;
    } vec_t;

    vec_t vecs [10];

    sm_run_ctrl #(.CNT_W(16), .RUN_ON_RESET(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .bp_en      (bp_en),
        .bp_pc      (bp_pc),
        .cpu_en     (cpu_en),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .halted     (halted),
        .bp_hit     (bp_hit)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Core model: PC advances by one word per enabled clock
    always @(posedge clk) begin
        if (pc_load) pc <= pc_load_val;
        else if (cpu_en) pc <= pc + 32'd1;
    end

    assign reg_data = (reg_addr == 5'd0) ? pc : rf[reg_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_arg   = 16'd0;
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_load     = 1'b1;
        pc_load_val = v;
        tick();
        pc_load     = 1'b0;
    endtask

    // Main test sequence
    initial begin
        logic [31:0] p0;
        logic [31:0] exp_d;
        int          beat;
        int          ready_err;

        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'hA5A5_0000 + 32'(i) * 32'h0001_0203;

        vecs[0] = '{OP_STEP, 16'd5, 5, 1'b1, 5};
        vecs[1] = '{OP_STEP, 16'd0, 3, 1'b1, 0};
        vecs[2] = '{OP_HALT, 16'd0, 2, 1'b1, 0};
        vecs[3] = '{OP_STEP, 16'd1, 1, 1'b1, 1};
        vecs[4] = '{OP_STEP, 16'd3, 2, 1'b0, 2};
        vecs[5] = '{OP_HALT, 16'd0, 1, 1'b1, 1};
        vecs[6] = '{OP_RUN,  16'd0, 3, 1'b0, 3};
        vecs[7] = '{OP_STEP, 16'd7, 2, 1'b0, 3};
        vecs[8] = '{OP_DUMP, 16'd0, 1, 1'b0, 2};
        vecs[9] = '{OP_HALT, 16'd0, 2, 1'b1, 1};

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 2'd0;
        cmd_arg     = 16'd0;
        bp_en       = 1'b0;
        bp_pc       = 32'd0;
        dump_ready  = 1'b0;
        pc_load     = 1'b1;
        pc_load_val = 32'd0;
        tick();
        tick();

        // Reset values (leaves reset in RUN)
        check("rst_halted", halted, 0);
        check("rst_cpu_en", cpu_en, 1);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_dump_valid", dump_valid, 0);
        check("rst_dump_idx", dump_idx, 0);
        check("rst_dump_data", dump_data, 0);
        check("rst_bp_hit", bp_hit, 0);

        rst_n   = 1'b1;
        pc_load = 1'b0;
        repeat (4) tick();
        check("run_pc", pc, 32'd4);
        check("run_halted", halted, 0);

        send(OP_HALT, 16'd0);
        check("halt_pc", pc, 32'd5);
        check("halt_halted", halted, 1);
        check("halt_cpu_en", cpu_en, 0);

        // Command decode vectors, breakpoint disabled
        for (int v = 0; v < 10; v++) begin
            p0 = pc;
            send(vecs[v].op, vecs[v].arg);
            repeat (vecs[v].extra) tick();
            check($sformatf("vec%0d_halted", v), halted, vecs[v].exp_halted);
            check($sformatf("vec%0d_pc_delta", v), pc - p0, 32'(vecs[v].exp_delta));
            check($sformatf("vec%0d_cpu_en", v), cpu_en, !vecs[v].exp_halted);
            check($sformatf("vec%0d_bp_hit", v), bp_hit, 0);
        end

        // HALT during STEP 100 on the third enabled cycle
        p0 = pc;
        send(OP_STEP, 16'd100);
        tick();
        tick();
        send(OP_HALT, 16'd0);
        tick();
        check("step_halt_pc_delta", pc - p0, 32'd3);
        check("step_halt_halted", halted, 1);

        // Breakpoint at PC 8, run from PC 0
        load_pc(32'd0);
        bp_pc = 32'd8;
        bp_en = 1'b1;
        send(OP_RUN, 16'd0);
        for (int i = 0; i < 40 && !halted; i++) begin
            if (pc == 32'd8) check("bp_cpu_en_drop", cpu_en, 0);
            tick();
        end
        check("bp_halted", halted, 1);
        check("bp_pc_stop", pc, 32'd8);
        check("bp_hit_set", bp_hit, 1);

        // Resume from the breakpointed PC
        send(OP_RUN, 16'd0);
        check("bp_resume_hit_clr", bp_hit, 0);
        check("bp_resume_halted", halted, 0);
        repeat (3) tick();
        check("bp_resume_pc", pc, 32'd11);
        send(OP_HALT, 16'd0);
        check("bp_resume_stop_pc", pc, 32'd12);

        // HALT command coinciding with a breakpoint hit
        load_pc(32'd0);
        bp_pc = 32'd2;
        send(OP_RUN, 16'd0);
        tick();
        tick();
        check("bp_sim_cpu_en", cpu_en, 0);
        send(OP_HALT, 16'd0);
        check("bp_sim_halted", halted, 1);
        check("bp_sim_hit", bp_hit, 1);
        check("bp_sim_pc", pc, 32'd2);
        bp_en = 1'b0;

        // Register dump with dump_ready toggling
        load_pc(32'h0000_0040);
        check("dump_pre_ready", cmd_ready, 1);
        send(OP_DUMP, 16'd0);
        check("dump_acc_ready", cmd_ready, 0);
        check("dump_acc_valid", dump_valid, 0);
        tick();
        check("dump_first_valid", dump_valid, 1);
        check("dump_first_idx", dump_idx, 0);
        check("dump_first_pc", dump_data, 32'h0000_0040);
        beat      = 0;
        ready_err = 0;
        for (int cyc = 0; cyc < 400 && beat < 32; cyc++) begin
            dump_ready = (cyc % 2) == 1;
            if (cmd_ready !== 1'b0) ready_err++;
            if (dump_valid && dump_ready) begin
                exp_d = (beat == 0) ? 32'h0000_0040 : rf[beat];
                check($sformatf("dump_idx_b%0d", beat), dump_idx, 32'(beat));
                check($sformatf("dump_data_b%0d", beat), dump_data, exp_d);
                beat++;
            end
            tick();
        end
        dump_ready = 1'b0;
        check("dump_beats", beat, 32);
        check("dump_cmd_ready_low", ready_err, 0);
        check("dump_end_halted", halted, 1);
        check("dump_end_reg_addr", reg_addr, 0);
        check("dump_end_valid", dump_valid, 0);
        check("dump_end_cmd_ready", cmd_ready, 1);

        // Asynchronous reset partway through a dump
        send(OP_DUMP, 16'd0);
        dump_ready = 1'b1;
        repeat (5) tick();
        check("mid_dump_reg_addr", reg_addr, 2);
        rst_n = 1'b0;
        #1;
        check("arst_dump_valid", dump_valid, 0);
        check("arst_reg_addr", reg_addr, 0);
        check("arst_dump_idx", dump_idx, 0);
        check("arst_dump_data", dump_data, 0);
        check("arst_bp_hit", bp_hit, 0);
        check("arst_halted", halted, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        dump_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_arst_cpu_en", cpu_en, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
